// File: rtl/spi_slave_reg_bank.sv
// Command decoder and register bank between the SPI byte receiver and transmitter.
// Responds 1 clk after each received byte; no backpressure (the master paces bytes >= 4 clk apart).
// Define SPI_REG_AUTOINC_EN for burst access (address steps after every data byte).
module spi_slave_reg_bank #(
    parameter int          DEPTH   = 16,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_cs,
    input  logic                 rover,
    input  logic [7:0]           rdata,
    output logic                 txd_en,
    output logic [7:0]           txd_data,
    output logic                 wr_pulse,
    output logic [6:0]           wr_addr,
    output logic [DEPTH*8-1:0]   reg_flat
);

`ifdef SPI_REG_AUTOINC_EN
    localparam logic [6:0] ADDR_STEP = 7'd1;
`else
    localparam logic [6:0] ADDR_STEP = 7'd0;
`endif

    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;

    state_t     state, state_nxt;
    logic       cs_meta, cs_s;
    logic [6:0] addr, addr_nxt;
    logic [6:0] ld_addr;
    logic       ld_en, wr_en;
    logic       addr_ok;
    logic [7:0] rd_byte;
    logic [7:0] regs [DEPTH];

    // Chip select is asynchronous to clk; idle (high) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
        end else begin
            cs_meta <= spi_cs;
            cs_s    <= cs_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_s) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = CMD;
                CMD:     if (rover) state_nxt = rdata[7] ? RD : WR;
                default: state_nxt = state;
            endcase
        end
    end

    assign addr_ok = ({25'd0, addr} < 32'(DEPTH));

    // A byte arriving in the cycle cs_s goes high is dropped: cs takes priority.
    always_comb begin
        addr_nxt = addr;
        ld_addr  = addr;
        ld_en    = 1'b0;
        wr_en    = 1'b0;
        if (!cs_s && rover) begin
            case (state)
                CMD: begin
                    addr_nxt = rdata[6:0];
                    ld_addr  = rdata[6:0];
                    ld_en    = rdata[7];
                end
                WR: begin
                    wr_en    = addr_ok;
                    addr_nxt = addr + ADDR_STEP;
                end
                RD: begin
                    addr_nxt = addr + ADDR_STEP;
                    ld_addr  = addr + ADDR_STEP;
                    ld_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Addresses past the bank read back as all ones.
    always_comb begin
        rd_byte = 8'hFF;
        for (int k = 0; k < DEPTH; k++) begin
            if (ld_addr == 7'(k)) rd_byte = regs[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= 7'd0;
            txd_en   <= 1'b0;
            txd_data <= 8'h00;
            wr_pulse <= 1'b0;
            wr_addr  <= 7'd0;
        end else begin
            addr     <= addr_nxt;
            txd_en   <= ld_en;
            wr_pulse <= wr_en;
            if (ld_en) txd_data <= rd_byte;
            if (wr_en) wr_addr  <= addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= RST_VAL;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_en && addr == 7'(k)) regs[k] <= rdata;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign reg_flat[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_spi_slave_reg_bank.sv
// Bench for spi_slave_reg_bank (DEPTH 16, RST_VAL 00): frame table plus cs-race and reset sequences.
// Expected bytes are queued when a frame is driven and popped when the DUT pulses.
module tb_spi_slave_reg_bank;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         spi_cs;
    logic         rover;
    logic [7:0]   rdata;
    logic         txd_en;
    logic [7:0]   txd_data;
    logic         wr_pulse;
    logic [6:0]   wr_addr;
    logic [127:0] reg_flat;

    int errors = 0;
    int checks = 0;

    spi_slave_reg_bank #(.DEPTH(16), .RST_VAL(8'h00)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_cs   (spi_cs),
        .rover    (rover),
        .rdata    (rdata),
        .txd_en   (txd_en),
        .txd_data (txd_data),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .reg_flat (reg_flat)
    );

    always #5 clk = ~clk;

    // Byte i of each 32-bit field is bits [8i+7:8i].
    typedef struct {
        logic [31:0] bytes; int nb;
        logic [31:0] txd;   int nt;
        logic [31:0] wa;
        logic [31:0] wd;    int nw;
    } vec_t;

    vec_t       vec [8];
    logic [7:0] txd_q [$];
    logic [15:0] wr_q [$];
    logic [7:0] mdl [16];
    logic       last_rover = 1'b0;
    logic [7:0] texp;
    logic [15:0] wexp;
    logic [7:0] wact;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic logic [127:0] img();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = mdl[k];
        return r;
    endfunction

    always @(negedge clk) begin
        if (txd_en) begin
            chk("txd_latency", {127'd0, last_rover}, 128'd1);
            if (txd_q.size() == 0) begin
                chk("txd_unexpected", {120'd0, txd_data}, 128'd0 - 128'd1);
            end else begin
                texp = txd_q.pop_front();
                chk("txd_data", {120'd0, txd_data}, {120'd0, texp});
            end
        end
        if (wr_pulse) begin
            chk("wr_latency", {127'd0, last_rover}, 128'd1);
            wact = (wr_addr < 7'd16) ? reg_flat[8*wr_addr[3:0] +: 8] : 8'hFF;
            if (wr_q.size() == 0) begin
                chk("wr_unexpected", {113'd0, wr_addr, wact}, 128'd0 - 128'd1);
            end else begin
                wexp = wr_q.pop_front();
                chk("wr_addr_data", {113'd0, wr_addr, wact}, {113'd0, wexp[14:0]});
            end
        end
        last_rover = rover;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #2;
        rdata = b;
        rover = 1'b1;
        @(posedge clk); #2;
        rover = 1'b0;
        rdata = 8'h00;
        repeat (5) @(posedge clk);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        mdl[a[3:0]] = d;
    endtask

    task automatic end_frame(input string nm);
        repeat (2) @(posedge clk); #2;
        spi_cs = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk({nm, "_txd_left"}, 128'(txd_q.size()), 128'd0);
        chk({nm, "_wr_left"},  128'(wr_q.size()),  128'd0);
        chk({nm, "_reg_flat"}, reg_flat, img());
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        for (int i = 0; i < v.nt; i++) txd_q.push_back(v.txd[8*i +: 8]);
        for (int i = 0; i < v.nw; i++) push_wr(v.wa[8*i +: 8], v.wd[8*i +: 8]);
        @(posedge clk); #2;
        spi_cs = 1'b0;
        repeat (4) @(posedge clk);
        for (int i = 0; i < v.nb; i++) send_byte(v.bytes[8*i +: 8]);
        end_frame($sformatf("vec%0d", idx));
    endtask

    initial begin
        // write 02 A5 5A / read 82 00 00 / oob write 14 77 / oob read 94
        // write 7F 11 22 (wrap) / write 0F C3 / read 8F 00 / read 80 00
`ifdef SPI_REG_AUTOINC_EN
        vec[0] = '{32'h005AA502, 3, 32'h0,        0, 32'h0302, 32'h5AA5, 2};
        vec[1] = '{32'h00000082, 3, 32'h00005AA5, 3, 32'h0,    32'h0,    0};
        vec[4] = '{32'h0022117F, 3, 32'h0,        0, 32'h00,   32'h22,   1};
        vec[6] = '{32'h0000008F, 2, 32'h0000FFC3, 2, 32'h0,    32'h0,    0};
        vec[7] = '{32'h00000080, 2, 32'h00000022, 2, 32'h0,    32'h0,    0};
`else
        vec[0] = '{32'h005AA502, 3, 32'h0,        0, 32'h0202, 32'h5AA5, 2};
        vec[1] = '{32'h00000082, 3, 32'h005A5A5A, 3, 32'h0,    32'h0,    0};
        vec[4] = '{32'h0022117F, 3, 32'h0,        0, 32'h0,    32'h0,    0};
        vec[6] = '{32'h0000008F, 2, 32'h0000C3C3, 2, 32'h0,    32'h0,    0};
        vec[7] = '{32'h00000080, 2, 32'h00000000, 2, 32'h0,    32'h0,    0};
`endif
        vec[2] = '{32'h00007714, 2, 32'h0,        0, 32'h0,    32'h0,    0};
        vec[3] = '{32'h00000094, 1, 32'h000000FF, 1, 32'h0,    32'h0,    0};
        vec[5] = '{32'h0000C30F, 2, 32'h0,        0, 32'h0F,   32'hC3,   1};

        for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
        rst_n = 1'b0; spi_cs = 1'b1; rover = 1'b0; rdata = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_reg_flat", reg_flat, 128'd0);
        chk("rst_txd_en",   {127'd0, txd_en},   128'd0);
        chk("rst_wr_pulse", {127'd0, wr_pulse}, 128'd0);
        chk("rst_txd_data", {120'd0, txd_data}, 128'd0);
        chk("rst_wr_addr",  {121'd0, wr_addr},  128'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec(vec[i], i);

        // cs_s rises in the exact cycle a data byte is sampled: byte must be dropped.
        @(posedge clk); #2;
        spi_cs = 1'b0;
        repeat (4) @(posedge clk);
        send_byte(8'h03);
        @(posedge clk); #2;
        spi_cs = 1'b1;
        repeat (2) @(posedge clk); #2;
        rdata = 8'hEE; rover = 1'b1;
        @(posedge clk); #2;
        rover = 1'b0;
        repeat (5) @(posedge clk);
        send_byte(8'hDD);
        @(negedge clk);
        chk("csrace_wr_left", 128'(wr_q.size()), 128'd0);
        chk("csrace_reg_flat", reg_flat, img());
        txd_q.push_back(mdl[3]);
        @(posedge clk); #2;
        spi_cs = 1'b0;
        repeat (4) @(posedge clk);
        send_byte(8'h83);
        end_frame("csrace_cmd");

        // Reset in the middle of a write frame, then decode a fresh command.
        @(posedge clk); #2;
        spi_cs = 1'b0;
        repeat (4) @(posedge clk);
        push_wr(8'h05, 8'h99);
        send_byte(8'h05);
        send_byte(8'h99);
        @(posedge clk); #2;
        rst_n = 1'b0;
        for (int k = 0; k < 16; k++) mdl[k] = 8'h00;
        @(negedge clk);
        chk("midrst_reg_flat", reg_flat, 128'd0);
        chk("midrst_txd_en",   {127'd0, txd_en}, 128'd0);
        chk("midrst_wr_pulse", {127'd0, wr_pulse}, 128'd0);
        repeat (2) @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        txd_q.push_back(8'h00);
        txd_q.push_back(8'h00);
        send_byte(8'h85);
        send_byte(8'h00);
        end_frame("midrst_cmd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
